exec_lavagem: RTL

EXEC_LAVAGEM -- requirements
Module: exec_lavagem

---
 rtl/exec_lavagem.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/exec_lavagem.sv
// exec_lavagem: washing-machine program sequencer (Moore FSM).
//   Runs the wash program ENCHER -> LAVAR -> DRENAR -> CENTRIFUGAR -> FIM
//   or the dry program SECAR -> FIM. The wash length scales with the
//   latched mode, and the program can be frozen with pausa.
// Ports:
//   clk, rst        clock; synchronous active-low reset
//   modo[2:0]       program selector (latched on start)
//   start           run request, only honoured in IDLE with the door closed
//   porta           door closed (1) sensor; opening it aborts to ERRO
//   pausa           freeze the running program
//   fase[2:0]       current phase code
//   valvula, bomba, resist, motor[1:0]   actuators
//   trava           door lock
//   fim, erro       done / error flags
//   restante[7:0]   cycles left in the current timed phase
module exec_lavagem #(
    parameter int unsigned T_FILL  = 4,
    parameter int unsigned T_WASH  = 8,
    parameter int unsigned T_DRAIN = 3,
    parameter int unsigned T_SPIN  = 5,
    parameter int unsigned T_DRY   = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] modo,
    input  logic       start,
    input  logic       porta,
    input  logic       pausa,
    output logic [2:0] fase,
    output logic       valvula,
    output logic       bomba,
    output logic       resist,
    output logic       trava,
    output logic       fim,
    output logic       erro,
    output logic [1:0] motor,
    output logic [7:0] restante
);

    localparam int unsigned CNT_W = 8;

    // Counter load values are duration-1 so each phase lasts its full duration.
    localparam logic [CNT_W-1:0] LD_FILL  = CNT_W'(T_FILL - 1);
    localparam logic [CNT_W-1:0] LD_WASH1 = CNT_W'(T_WASH - 1);
    localparam logic [CNT_W-1:0] LD_WASH2 = CNT_W'(2 * T_WASH - 1);
    localparam logic [CNT_W-1:0] LD_WASH3 = CNT_W'(3 * T_WASH - 1);
    localparam logic [CNT_W-1:0] LD_DRAIN = CNT_W'(T_DRAIN - 1);
    localparam logic [CNT_W-1:0] LD_SPIN  = CNT_W'(T_SPIN - 1);
    localparam logic [CNT_W-1:0] LD_DRY   = CNT_W'(T_DRY - 1);

    localparam logic [2:0] M_MENU = 3'b000;
    localparam logic [2:0] M_SEC  = 3'b001;
    localparam logic [2:0] M_ECO  = 3'b010;
    localparam logic [2:0] M_NORM = 3'b011;
    localparam logic [2:0] M_PES  = 3'b100;

    localparam logic [1:0] MOT_OFF  = 2'b00;
    localparam logic [1:0] MOT_SLOW = 2'b01;
    localparam logic [1:0] MOT_FAST = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE   = 3'b000,
        S_ENCHER = 3'b001,
        S_LAVAR  = 3'b010,
        S_DRENAR = 3'b011,
        S_CENTRI = 3'b100,
        S_SECAR  = 3'b101,
        S_FIM    = 3'b110,
        S_ERRO   = 3'b111
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       mode_q, mode_d;
    logic             pause_q, pause_d;
    logic [CNT_W-1:0] wash_load;
    logic             timed;

    // Wash length follows the latched mode, never the live selector.
    always_comb begin
        case (mode_q)
            M_NORM:  wash_load = LD_WASH2;
            M_PES:   wash_load = LD_WASH3;
            default: wash_load = LD_WASH1;
        endcase
    end

    assign timed = (state_q == S_ENCHER) || (state_q == S_LAVAR) ||
                   (state_q == S_DRENAR) || (state_q == S_CENTRI) ||
                   (state_q == S_SECAR);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            mode_q  <= '0;
            pause_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            pause_q <= pause_d;
        end
    end

    // Next-state logic: door open beats pause, pause beats phase completion.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        pause_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (start && porta) begin
                    mode_d = modo;
                    case (modo)
                        M_MENU: state_d = S_IDLE;
                        M_SEC: begin
                            state_d = S_SECAR;
                            cnt_d   = LD_DRY;
                        end
                        M_ECO, M_NORM, M_PES: begin
                            state_d = S_ENCHER;
                            cnt_d   = LD_FILL;
                        end
                        default: state_d = S_ERRO;
                    endcase
                end
            end
            S_ENCHER, S_LAVAR, S_DRENAR, S_CENTRI, S_SECAR: begin
                if (!porta) begin
                    state_d = S_ERRO;
                    cnt_d   = '0;
                end else if (pausa) begin
                    pause_d = 1'b1;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    case (state_q)
                        S_ENCHER: begin
                            state_d = S_LAVAR;
                            cnt_d   = wash_load;
                        end
                        S_LAVAR: begin
                            state_d = S_DRENAR;
                            cnt_d   = LD_DRAIN;
                        end
                        S_DRENAR: begin
                            state_d = S_CENTRI;
                            cnt_d   = LD_SPIN;
                        end
                        default: begin
                            state_d = S_FIM;
                            cnt_d   = '0;
                        end
                    endcase
                end
            end
            S_FIM, S_ERRO: begin
                cnt_d = '0;
                if (modo == M_MENU) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Output decode from registered state, counter and pause flag.
    always_comb begin
        fase     = S_IDLE;
        valvula  = 1'b0;
        bomba    = 1'b0;
        resist   = 1'b0;
        motor    = MOT_OFF;
        trava    = 1'b0;
        fim      = 1'b0;
        erro     = 1'b0;
        restante = '0;
        case (state_q)
            S_ENCHER, S_LAVAR, S_DRENAR, S_CENTRI, S_SECAR: fase = state_q;
            S_FIM:  fase = S_FIM;
            S_ERRO: fase = S_ERRO;
            default: fase = S_IDLE;
        endcase
        if (timed) begin
            trava    = 1'b1;
            restante = cnt_q;
            if (!pause_q) begin
                case (state_q)
                    S_ENCHER: valvula = 1'b1;
                    S_LAVAR:  motor = MOT_SLOW;
                    S_DRENAR: bomba = 1'b1;
                    S_CENTRI: begin
                        motor = MOT_FAST;
                        bomba = 1'b1;
                    end
                    S_SECAR: begin
                        resist = 1'b1;
                        motor  = MOT_SLOW;
                    end
                    default: motor = MOT_OFF;
                endcase
            end
        end
        fim  = (state_q == S_FIM);
        erro = (state_q == S_ERRO);
    end

endmodule
